// File: rtl/adc_preview_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_preview_pkg
// Purpose  : Shared state encoding and default constants for the preview sequencer.
// Revision : 1.0
// ============================================================================
package adc_preview_pkg;

  localparam int ADDR_W          = 9;
  localparam int DEF_POINTS      = 512;
  localparam int DEF_RD_LAT      = 2;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ACK_W       = 4;
  localparam int DEF_TIMEOUT_CYC = 100000000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    WAIT_RDY = 3'd2,
    READ     = 3'd3,
    DRAIN    = 3'd4,
    ACK      = 3'd5,
    WAIT_CLR = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/prev_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : prev_sync_fifo
// Purpose  : Small synchronous first-word-fall-through FIFO with occupancy count.
// Revision : 1.0
// ============================================================================
module prev_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && (count_q != CNT_W'(DEPTH));
    do_rd    = rd_en && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    // Storage needs no reset: a slot is only read after it has been written.
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/adc_preview_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_preview_ctrl
// Purpose  : Arms the preview buffer, streams each ready frame out, then ACKs it.
// Revision : 1.0
// ============================================================================
module adc_preview_ctrl
  import adc_preview_pkg::*;
#(
  parameter int POINTS      = DEF_POINTS,
  parameter int RD_LAT      = DEF_RD_LAT,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int ACK_W       = DEF_ACK_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              cfg_continuous,
  input  logic [15:0]       cfg_decim,
  input  logic              clr_err,
  output logic              preview_start,
  output logic [15:0]       decim_val,
  input  logic              data_ready,
  output logic              data_ack,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [7:0]        bram_dout,
  output logic              m_valid,
  output logic [7:0]        m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              err_timeout
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(POINTS - 1);
  localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [15:0]       ACK_LAST  = 16'(ACK_W - 1);

  state_e              state_q, state_d;
  logic [15:0]         decim_q, decim_d;
  logic                preview_start_q, preview_start_d;
  logic                data_ack_q, data_ack_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic                issued_q, issued_d;
  logic                issued_last_q, issued_last_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [RD_LAT-1:0]   lst_q, lst_d;
  logic [15:0]         frame_q, frame_d;
  logic                err_q, err_d;
  logic                stop_q, stop_d;
  logic [31:0]         tmo_q, tmo_d;
  logic [15:0]         ack_cnt_q, ack_cnt_d;

  logic [7:0]          inflight;
  logic                can_issue;
  logic                tmo_hit;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_cnt;
  logic [8:0]          fifo_rdata;
  logic                pop;

  // issued_q marks the cycle the address is on the port; vld/lst follow it
  // so the pipeline tail lines up with the matching bram_dout.
  always_comb begin
    vld_d[0] = issued_q;
    lst_d[0] = issued_last_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end
    inflight = {7'd0, issued_q};
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + {7'd0, vld_q[i]};
    can_issue = (inflight + 8'(fifo_cnt)) < 8'(FIFO_DEPTH);
    tmo_hit   = (TIMEOUT_CYC != 0) && (tmo_q == TMO_LAST);
  end

  always_comb begin
    state_d       = state_q;
    decim_d       = decim_q;
    addr_d        = addr_q;
    next_addr_d   = next_addr_q;
    issued_d      = 1'b0;
    issued_last_d = 1'b0;
    frame_d       = frame_q;
    err_d         = err_q & ~clr_err;
    stop_d        = stop_q;
    tmo_d         = tmo_q;
    ack_cnt_d     = ack_cnt_q;

    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (cfg_start) begin
          decim_d = cfg_decim;
          state_d = ARM;
        end
      end
      ARM: begin
        if (cfg_stop) stop_d = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        tmo_d = tmo_q + 32'd1;
        if (cfg_stop || stop_q) begin
          state_d = IDLE;
        end else if (data_ready) begin
          addr_d      = '0;
          next_addr_d = '0;
          state_d     = READ;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      READ: begin
        if (cfg_stop) stop_d = 1'b1;
        if (can_issue) begin
          addr_d        = next_addr_q;
          next_addr_d   = next_addr_q + 1'b1;
          issued_d      = 1'b1;
          issued_last_d = (next_addr_q == LAST_ADDR);
          if (next_addr_q == LAST_ADDR) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cfg_stop) stop_d = 1'b1;
        if (inflight == 8'd0 && fifo_empty) begin
          ack_cnt_d = '0;
          state_d   = ACK;
        end
      end
      ACK: begin
        if (cfg_stop) stop_d = 1'b1;
        ack_cnt_d = ack_cnt_q + 16'd1;
        if (ack_cnt_q == ACK_LAST) begin
          tmo_d   = '0;
          state_d = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        tmo_d = tmo_q + 32'd1;
        if (!data_ready) begin
          // Only re-arm once READY is low, so a stale READY is never re-read.
          frame_d = frame_q + 16'd1;
          tmo_d   = '0;
          state_d = (cfg_continuous && !stop_q && !cfg_stop) ? WAIT_RDY : IDLE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cfg_stop) begin
          stop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    preview_start_d = (state_d != IDLE);
    data_ack_d      = (state_d == ACK);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q         <= IDLE;
      decim_q         <= '0;
      preview_start_q <= 1'b0;
      data_ack_q      <= 1'b0;
      addr_q          <= '0;
      next_addr_q     <= '0;
      issued_q        <= 1'b0;
      issued_last_q   <= 1'b0;
      vld_q           <= '0;
      lst_q           <= '0;
      frame_q         <= '0;
      err_q           <= 1'b0;
      stop_q          <= 1'b0;
      tmo_q           <= '0;
      ack_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      decim_q         <= decim_d;
      preview_start_q <= preview_start_d;
      data_ack_q      <= data_ack_d;
      addr_q          <= addr_d;
      next_addr_q     <= next_addr_d;
      issued_q        <= issued_d;
      issued_last_q   <= issued_last_d;
      vld_q           <= vld_d;
      lst_q           <= lst_d;
      frame_q         <= frame_d;
      err_q           <= err_d;
      stop_q          <= stop_d;
      tmo_q           <= tmo_d;
      ack_cnt_q       <= ack_cnt_d;
    end
  end

  assign pop = m_valid && m_ready;

  prev_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (HCLK),
    .rst     (HRESET),
    .wr_en   (vld_q[RD_LAT-1]),
    .wr_data ({lst_q[RD_LAT-1], bram_dout}),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign m_valid       = !fifo_empty;
  assign m_data        = fifo_empty ? 8'd0 : fifo_rdata[7:0];
  assign m_last        = !fifo_empty && fifo_rdata[8];
  assign preview_start = preview_start_q;
  assign decim_val     = decim_q;
  assign data_ack      = data_ack_q;
  assign bram_addr     = addr_q;
  assign busy          = (state_q != IDLE);
  assign frame_cnt     = frame_q;
  assign err_timeout   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_preview_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_preview_ctrl
// Purpose  : Scoreboard bench: buffer/BRAM model drives frames, monitor checks the stream.
// Revision : 1.0
// ============================================================================
module tb_adc_preview_ctrl;

  localparam int POINTS = 512;
  localparam int ACK_W  = 4;
  localparam int TMO    = 1200;

  logic        HCLK;
  logic        HRESET;
  logic        cfg_start, cfg_stop, cfg_continuous, clr_err;
  logic [15:0] cfg_decim;
  logic        preview_start, data_ready, data_ack;
  logic [15:0] decim_val;
  logic [8:0]  bram_addr;
  logic [7:0]  bram_dout;
  logic        m_valid, m_last, busy, err_timeout;
  logic [7:0]  m_data;
  logic        m_ready = 1'b1;
  logic [15:0] frame_cnt;

  int          checks = 0;
  int          errors = 0;
  int          pop_cnt = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  mon_exp;
  logic [8:0]  hold_val;
  logic        hold_v = 1'b0;
  logic [7:0]  key = 8'h00;
  logic        rnd_mode = 1'b0;
  logic [8:0]  p0, p1;

  adc_preview_ctrl #(
    .POINTS      (POINTS),
    .RD_LAT      (2),
    .FIFO_DEPTH  (4),
    .ACK_W       (ACK_W),
    .TIMEOUT_CYC (TMO)
  ) u_dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_continuous (cfg_continuous),
    .cfg_decim      (cfg_decim),
    .clr_err        (clr_err),
    .preview_start  (preview_start),
    .decim_val      (decim_val),
    .data_ready     (data_ready),
    .data_ack       (data_ack),
    .bram_addr      (bram_addr),
    .bram_dout      (bram_dout),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .busy           (busy),
    .frame_cnt      (frame_cnt),
    .err_timeout    (err_timeout)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Two-cycle BRAM: dout in cycle k reflects the address of cycle k-2.
  always @(posedge HCLK) begin
    p0 <= bram_addr;
    p1 <= p0;
  end
  assign bram_dout = p1[7:0] ^ key;

  always @(posedge HCLK) begin
    #1;
    m_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual wait expired, required DUT event", name);
  endtask

  // Stream monitor: pops the scoreboard on each handshake, checks hold under stall.
  always @(negedge HCLK) begin
    if (m_valid && hold_v) chk("stall_hold", {55'd0, m_last, m_data}, {55'd0, hold_val});
    if (m_valid && m_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: actual 0x%0h, required no byte", {m_last, m_data});
      end else begin
        mon_exp = exp_q.pop_front();
        chk("stream_byte", {55'd0, m_last, m_data}, {55'd0, mon_exp});
      end
      hold_v = 1'b0;
    end else if (m_valid) begin
      hold_v   = 1'b1;
      hold_val = {m_last, m_data};
    end else begin
      hold_v = 1'b0;
    end
  end

  function automatic logic [63:0] out_vec();
    return {9'd0, preview_start, decim_val, data_ack, bram_addr, m_valid, m_data,
            m_last, busy, frame_cnt, err_timeout};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] decim);
    cfg_decim = decim;
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < POINTS; i++)
      exp_q.push_back({(i == POINTS - 1), 8'(i) ^ key});
  endtask

  // Buffer model: raise READY, wait for ACK, measure it, hold READY 16 more cycles.
  task automatic serve_frame(input int delay);
    int n;
    tick(delay);
    push_frame();
    data_ready = 1'b1;
    n = 0;
    while (!data_ack && n < 20000) begin tick(1); n++; end
    if (!data_ack) note_fail("ack_wait");
    n = 0;
    while (data_ack && n < 100) begin tick(1); n++; end
    chk("ack_width", n, ACK_W);
    tick(16);
    data_ready = 1'b0;
    tick(2);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: actual no finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    HRESET = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_continuous = 1'b0;
    cfg_decim = 16'h0; clr_err = 1'b0; data_ready = 1'b0;
    tick(4);
    HRESET = 1'b0;
    tick(1);
    chk("reset_outputs", out_vec(), 64'd0);

    // Single shot, dout = address.
    key = 8'h00;
    pulse_start(16'h1234);
    chk("decim_latch", decim_val, 16'h1234);
    chk("preview_start_arm", {busy, preview_start}, 2'b11);
    serve_frame(1000);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_idle", {busy, preview_start, data_ack}, 3'b000);
    chk("t1_sb_empty", exp_q.size(), 0);

    // 30% ready duty.
    rnd_mode = 1'b1;
    key = 8'h5A;
    pulse_start(16'h0003);
    serve_frame(200);
    rnd_mode = 1'b0;
    chk("t2_frame_cnt", frame_cnt, 2);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Continuous, three frames.
    cfg_continuous = 1'b1;
    key = 8'hC3;
    pulse_start(16'h0010);
    serve_frame(50);
    chk("t3_rearm_busy", busy, 1);
    chk("t3_frame_cnt1", frame_cnt, 3);
    serve_frame(50);
    cfg_continuous = 1'b0;
    serve_frame(50);
    chk("t3_frame_cnt", frame_cnt, 5);
    chk("t3_idle", busy, 0);
    chk("t3_sb_empty", exp_q.size(), 0);

    // Stop at byte 100 in continuous mode; start during run ignored.
    cfg_continuous = 1'b1;
    key = 8'h0F;
    pulse_start(16'h0044);
    base = pop_cnt;
    fork
      serve_frame(30);
      begin
        n = 0;
        while (pop_cnt < base + 100 && n < 5000) begin tick(1); n++; end
        if (pop_cnt < base + 100) note_fail("t4_byte100_wait");
        cfg_stop = 1'b1;
        tick(1);
        cfg_stop = 1'b0;
        pulse_start(16'hBEEF);
      end
    join
    tick(3);
    chk("t4_idle", {busy, preview_start}, 2'b00);
    chk("t4_frame_cnt", frame_cnt, 6);
    chk("t4_decim_kept", decim_val, 16'h0044);
    chk("t4_sb_empty", exp_q.size(), 0);
    cfg_continuous = 1'b0;

    // Timeout: READY never asserted.
    pulse_start(16'h0055);
    tick(TMO);
    chk("t5_before_tmo", {err_timeout, busy}, 2'b01);
    tick(1);
    chk("t5_tmo", {err_timeout, busy, preview_start}, 3'b100);
    tick(3);
    chk("t5_sticky", err_timeout, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("t5_clr", err_timeout, 0);

    // HRESET mid-READ, then a clean frame.
    key = 8'h77;
    pulse_start(16'h0101);
    tick(20);
    push_frame();
    base = pop_cnt;
    data_ready = 1'b1;
    n = 0;
    while (pop_cnt < base + 40 && n < 5000) begin tick(1); n++; end
    if (pop_cnt < base + 40) note_fail("t6_read_wait");
    HRESET = 1'b1;
    tick(1);
    chk("t6_reset_outputs", out_vec(), 64'd0);
    HRESET = 1'b0;
    data_ready = 1'b0;
    exp_q.delete();
    tick(2);
    pulse_start(16'h0202);
    serve_frame(10);
    chk("t6_frame_cnt", frame_cnt, 1);
    chk("t6_idle", busy, 0);
    chk("t6_decim", decim_val, 16'h0202);

    tick(5);
    chk("final_sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
